// File: rtl/pulse_formatter_handshake_param.sv
// Square-wave formatter with programmable low/high phase lengths.
// A new pair of lengths is fetched from the converter over soc/eoc during
// every high phase. If the converter is slow, out is held high and late is
// raised until the converter answers.
module pulse_formatter_handshake_param #(
  parameter int WIDTH      = 8,
  parameter int DEFAULT_LO = 6,
  parameter int DEFAULT_HI = 6,
  parameter int ASYMMETRIC = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             eoc,
  input  logic [WIDTH-1:0] numero_lo,
  input  logic [WIDTH-1:0] numero_hi,
  output logic             soc,
  output logic             out,
  output logic             late
);

  typedef enum logic {PH_LOW, PH_HIGH} phase_e;
  typedef enum logic [1:0] {HS_IDLE, HS_WAIT_LO, HS_WAIT_HI, HS_READY} hs_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  phase_e           phase_q;
  hs_e              hs_q;
  logic             out_q;
  logic             soc_q;
  logic             late_q;
  logic [WIDTH-1:0] cnt_q;      // cycles left in the current phase, 1 = last
  logic [WIDTH-1:0] hi_len_q;   // length of the next high phase
  logic [WIDTH-1:0] pend_lo_q;  // captured values waiting for the phase end
  logic [WIDTH-1:0] pend_hi_q;

  logic [WIDTH-1:0] lo_clamp_d;
  logic [WIDTH-1:0] hi_clamp_d;
  logic [WIDTH-1:0] hi_sel_d;
  logic             lo_expire;
  logic             hi_expire;
  logic             capture;
  logic             consume;
  logic             direct;

  // Clamp sampled durations to at least one cycle and pick the high source.
  always_comb begin
    lo_clamp_d = (numero_lo == '0) ? ONE : numero_lo;
    hi_clamp_d = (numero_hi == '0) ? ONE : numero_hi;
    hi_sel_d   = (ASYMMETRIC != 0) ? hi_clamp_d : lo_clamp_d;
  end

  // A high phase "expires" on its last nominal cycle and on every stall cycle.
  // When the converter answers on an expiring edge the new values bypass the
  // pending registers, so a stall ends on exactly that edge.
  assign lo_expire = (phase_q == PH_LOW) && (cnt_q == ONE);
  assign hi_expire = (phase_q == PH_HIGH) && (late_q || (cnt_q == ONE));
  assign capture   = (hs_q == HS_WAIT_HI) && eoc;
  assign consume   = hi_expire && (hs_q == HS_READY);
  assign direct    = hi_expire && capture;

  // Phase FSM: counts the phase down and toggles out, stalling high if needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q  <= PH_LOW;
      out_q    <= 1'b0;
      late_q   <= 1'b0;
      cnt_q    <= WIDTH'(DEFAULT_LO);
      hi_len_q <= WIDTH'(DEFAULT_HI);
    end else begin
      case (phase_q)
        PH_LOW: begin
          if (lo_expire) begin
            phase_q <= PH_HIGH;
            out_q   <= 1'b1;
            cnt_q   <= hi_len_q;
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        PH_HIGH: begin
          if (hi_expire) begin
            if (consume) begin
              phase_q  <= PH_LOW;
              out_q    <= 1'b0;
              late_q   <= 1'b0;
              cnt_q    <= pend_lo_q;
              hi_len_q <= pend_hi_q;
            end else if (direct) begin
              phase_q  <= PH_LOW;
              out_q    <= 1'b0;
              late_q   <= 1'b0;
              cnt_q    <= lo_clamp_d;
              hi_len_q <= hi_sel_d;
            end else begin
              late_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: phase_q <= PH_LOW;
      endcase
    end
  end

  // Handshake FSM: one soc/eoc exchange per period, started as out rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_q      <= HS_IDLE;
      soc_q     <= 1'b0;
      pend_lo_q <= WIDTH'(DEFAULT_LO);
      pend_hi_q <= WIDTH'(DEFAULT_HI);
    end else begin
      case (hs_q)
        HS_IDLE: begin
          if (lo_expire) begin
            soc_q <= 1'b1;
            hs_q  <= HS_WAIT_LO;
          end
        end
        HS_WAIT_LO: begin
          if (!eoc) begin
            soc_q <= 1'b0;
            hs_q  <= HS_WAIT_HI;
          end
        end
        HS_WAIT_HI: begin
          if (capture) begin
            if (direct) begin
              hs_q <= HS_IDLE;
            end else begin
              pend_lo_q <= lo_clamp_d;
              pend_hi_q <= hi_sel_d;
              hs_q      <= HS_READY;
            end
          end
        end
        HS_READY: begin
          if (consume) hs_q <= HS_IDLE;
        end
        default: hs_q <= HS_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign soc  = soc_q;
  assign late = late_q;

endmodule

// File: tb/tb_pulse_formatter_handshake_param.sv
// Bench for pulse_formatter_handshake_param: one symmetric and one asymmetric
// instance, each driven by a converter responder with random latencies.
module tb_pulse_formatter_handshake_param;

  localparam int DEF_LO = 6;
  localparam int DEF_HI = 6;

  typedef struct {
    int hi;
    int late;
    int lo;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eoc_w [2];
  logic [7:0] lo_w  [2];
  logic [7:0] hi_w  [2];
  logic       soc_w [2];
  logic       out_w [2];
  logic       late_w[2];

  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  rec_t sb_q [2][$];
  int   pushed[2];
  int   popped[2];
  int   cur_h [2];

  always #5 clk = ~clk;

  pulse_formatter_handshake_param #(.WIDTH(8), .DEFAULT_LO(DEF_LO), .DEFAULT_HI(DEF_HI), .ASYMMETRIC(0)) u_sym (
    .clock(clk), .reset(rst), .eoc(eoc_w[0]), .numero_lo(lo_w[0]), .numero_hi(hi_w[0]),
    .soc(soc_w[0]), .out(out_w[0]), .late(late_w[0]));

  pulse_formatter_handshake_param #(.WIDTH(8), .DEFAULT_LO(DEF_LO), .DEFAULT_HI(DEF_HI), .ASYMMETRIC(1)) u_asym (
    .clock(clk), .reset(rst), .eoc(eoc_w[1]), .numero_lo(lo_w[1]), .numero_hi(hi_w[1]),
    .soc(soc_w[1]), .out(out_w[1]), .late(late_w[1]));

  task automatic check(input string name, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s inst%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Converter model: answers each soc with chosen latencies and predicts the
  // resulting period. The high phase ends at the later of its nominal length
  // and the answer edge; the excess is the time late is shown.
  task automatic respond(input int k, input int nper, input bit directed);
    int d1, d2, lo, hi, c, w;
    rec_t r;
    for (int p = 0; p < nper; p++) begin
      w = 0;
      while (soc_w[k] !== 1'b1 && w < 300) begin
        @(posedge clk); #1; w++;
      end
      if (w >= 300) begin
        check("soc_timeout", k, 0, 1);
        return;
      end
      d1 = $urandom_range(0, 4);
      d2 = $urandom_range(1, 6);
      lo = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      hi = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      if (directed && k == 0 && p < 4) begin
        case (p)
          0:       begin d1 = 0; d2 = 14; lo = 4;  hi = 0; end
          1:       begin d1 = 0; d2 = 1;  lo = 10; hi = 0; end
          2:       begin d1 = 0; d2 = 1;  lo = 25; hi = 0; end
          default: begin d1 = 0; d2 = 1;  lo = 0;  hi = 0; end
        endcase
      end else if (directed && k == 1 && p < 2) begin
        d1 = p; d2 = 1 + p; lo = 3; hi = 7;
      end
      repeat (d1) begin @(posedge clk); #1; end
      eoc_w[k] = 1'b0;
      repeat (d2) begin @(posedge clk); #1; end
      eoc_w[k] = 1'b1;
      lo_w[k]  = 8'(lo);
      hi_w[k]  = 8'(hi);
      c = d1 + d2 + 1;
      r.hi   = imax(cur_h[k], c);
      r.late = imax(0, c - cur_h[k]);
      r.lo   = clampv(lo);
      sb_q[k].push_back(r);
      pushed[k]++;
      cur_h[k] = (k == 1) ? clampv(hi) : clampv(lo);
    end
  endtask

  // Monitor: measures each high run and the low run after it, then compares
  // the whole period with the oldest prediction.
  initial begin : monitor
    int   m_run[2], m_late[2], m_soc[2];
    int   h_len[2], h_late[2], h_soc[2];
    bit   m_prev_out[2], m_prev_soc[2], m_first[2], m_have_hi[2];
    rec_t r;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!mon_en) begin
          m_run[k] = 0; m_late[k] = 0; m_soc[k] = 0;
          m_prev_out[k] = 1'b0; m_prev_soc[k] = 1'b0;
          m_first[k] = 1'b1; m_have_hi[k] = 1'b0;
        end else begin
          check("late_only_when_high", k, int'(late_w[k] && !out_w[k]), 0);
          if (out_w[k] != m_prev_out[k]) begin
            if (m_prev_out[k]) begin
              h_len[k] = m_run[k]; h_late[k] = m_late[k]; h_soc[k] = m_soc[k];
              m_have_hi[k] = 1'b1;
            end else if (m_first[k]) begin
              check("first_low_len", k, m_run[k], DEF_LO);
              check("soc_in_low", k, m_soc[k], 0);
              m_first[k] = 1'b0;
            end else if (m_have_hi[k]) begin
              if (sb_q[k].size() == 0) begin
                check("unexpected_period", k, 1, 0);
              end else begin
                r = sb_q[k].pop_front();
                popped[k]++;
                check("high_len", k, h_len[k], r.hi);
                check("late_cycles", k, h_late[k], r.late);
                check("soc_pulses", k, h_soc[k], 1);
                check("low_len", k, m_run[k], r.lo);
                $display("[TB] inst%0d period: high %0d late %0d low %0d", k, h_len[k], h_late[k], m_run[k]);
              end
            end
            m_run[k] = 0; m_late[k] = 0; m_soc[k] = 0;
          end
          m_run[k]++;
          if (late_w[k]) m_late[k]++;
          if (soc_w[k] && !m_prev_soc[k]) m_soc[k]++;
          m_prev_out[k] = out_w[k];
          m_prev_soc[k] = soc_w[k];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    for (int k = 0; k < 2; k++) begin
      eoc_w[k] = 1'b1; lo_w[k] = 8'd0; hi_w[k] = 8'd0;
      pushed[k] = 0; popped[k] = 0; cur_h[k] = DEF_HI;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_out", k, int'(out_w[k]), 0);
      check("reset_soc", k, int'(soc_w[k]), 0);
      check("reset_late", k, int'(late_w[k]), 0);
    end

    fork
      respond(0, 12, 1'b1);
      respond(1, 12, 1'b1);
    join
    repeat (80) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      check("periods_checked", k, popped[k], pushed[k]);
      check("scoreboard_empty", k, sb_q[k].size(), 0);
    end

    // Converter now silent: both instances sit in a stalled high phase with
    // soc up. A one-cycle reset must abort the handshake immediately.
    mon_en = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("soc_before_reset", k, int'(soc_w[k]), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) cur_h[k] = DEF_HI;
    mon_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("midreset_out", k, int'(out_w[k]), 0);
      check("midreset_soc", k, int'(soc_w[k]), 0);
      check("midreset_late", k, int'(late_w[k]), 0);
    end

    fork
      respond(0, 6, 1'b0);
      respond(1, 6, 1'b0);
    join
    repeat (80) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      check("periods_checked_2", k, popped[k], pushed[k]);
      check("scoreboard_empty_2", k, sb_q[k].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
